seg_value_display: RTL and testbench

Parametrised, clocked successor to the combinational volume readout. It takes a binary value with a valid strobe and converts it to BCD sequentially using shift-add-3 (double dabble). It drives DIGITS active-low seven-segment patterns, with optional leading-zero blanking and an auto-blank hold timer. It sits between control logic (volume, note, or octave level) and the HEX display pins.

---
 rtl/seg_disp_pkg.sv | 43 ++++
 rtl/bcd_dabble_seq.sv | 64 ++++++
 rtl/seg_value_display.sv | 161 ++++++++++++++++
 tb/tb_seg_value_display.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
// Shared types, constants and helpers for the seven-segment value display.
package seg_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_SHOW    = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // BCD digit to active-low segments, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg7_enc(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // True when DIGITS decimal digits can hold every VAL_W-bit value
    function automatic bit digits_ok(input int val_w, input int digits);
        longint unsigned lim;
        longint unsigned max_val;
        lim = 64'd1;
        for (int i = 0; i < digits; i++) begin
            lim = lim * 64'd10;
        end
        max_val = (64'd1 << val_w) - 64'd1;
        return lim > max_val;
    endfunction

endpackage

// File: rtl/bcd_dabble_seq.sv
// Sequential binary-to-BCD converter, one shift-add-3 step per clock.
// The first shift happens on the start edge itself (the BCD register is zero
// then, so no correction is needed), which puts the result out after VAL_W-1
// further edges; done_o is high in the cycle the final result is valid.
module bcd_dabble_seq #(
    parameter int VAL_W  = 7,
    parameter int DIGITS = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [VAL_W-1:0]      value_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DIGITS*4-1:0]   bcd_o
);

    localparam int CNT_W = $clog2(VAL_W + 1);

    logic [VAL_W-1:0]    bin_r;
    logic [DIGITS*4-1:0] bcd_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                busy_r;
    logic [DIGITS*4-1:0] adj_s;

    // Add-3 correction of every nibble that is 5 or more before the shift
    always_comb begin
        adj_s = bcd_r;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_r[4*k +: 4] >= 4'd5) begin
                adj_s[4*k +: 4] = bcd_r[4*k +: 4] + 4'd3;
            end else begin
                adj_s[4*k +: 4] = bcd_r[4*k +: 4];
            end
        end
    end

    // Shift register and step counter; a start always reloads, even mid-run
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bin_r  <= '0;
            bcd_r  <= '0;
            cnt_r  <= '0;
            busy_r <= 1'b0;
        end else if (start_i) begin
            bcd_r  <= {{(DIGITS*4-1){1'b0}}, value_i[VAL_W-1]};
            bin_r  <= value_i << 1;
            cnt_r  <= CNT_W'(VAL_W - 1);
            busy_r <= 1'b1;
        end else if (busy_r) begin
            if (cnt_r != '0) begin
                {bcd_r, bin_r} <= {adj_s, bin_r} << 1;
                cnt_r          <= cnt_r - 1'b1;
            end else begin
                busy_r <= 1'b0;
            end
        end
    end

    assign busy_o = busy_r;
    assign done_o = busy_r && (cnt_r == '0);
    assign bcd_o  = bcd_r;

endmodule

// File: rtl/seg_value_display.sv
// Clocked decimal readout: captures a strobed binary value, converts it to
// BCD, and drives active-low seven-segment digits with optional leading-zero
// blanking and an auto-blank hold timer.
module seg_value_display
    import seg_disp_pkg::*;
#(
    parameter int VAL_W       = 7,
    parameter int DIGITS      = 3,
    parameter int LZ_BLANK    = 1,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [VAL_W-1:0]      value_i,
    input  logic                  value_valid_i,
    output logic [DIGITS*7-1:0]   seg_o,
    output logic                  busy_o,
    output logic                  active_o,
    output logic                  done_o
);

    localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

    if (!digits_ok(VAL_W, DIGITS)) begin : g_bad_digits
        $error("seg_value_display: DIGITS cannot represent every VAL_W-bit value");
    end

    state_e              state_r;
    logic                pend_full_r;
    logic [VAL_W-1:0]    pend_val_r;
    logic [HOLD_W-1:0]   hold_r;
    logic [DIGITS*7-1:0] seg_r;
    logic                done_r;
    logic                active_r;

    logic                conv_start_s;
    logic [VAL_W-1:0]    conv_val_s;
    logic                conv_busy_s;
    logic                conv_done_s;
    logic [DIGITS*4-1:0] conv_bcd_s;
    logic [DIGITS*7-1:0] seg_next_s;
    logic                lead_s;

    bcd_dabble_seq #(
        .VAL_W  (VAL_W),
        .DIGITS (DIGITS)
    ) u_dabble (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (conv_start_s),
        .value_i (conv_val_s),
        .busy_o  (conv_busy_s),
        .done_o  (conv_done_s),
        .bcd_o   (conv_bcd_s)
    );

    // Choose when to (re)start the converter and which value it takes
    always_comb begin
        conv_start_s = 1'b0;
        conv_val_s   = value_i;
        case (state_r)
            ST_IDLE, ST_SHOW: begin
                if (value_valid_i) begin
                    conv_start_s = 1'b1;
                end else begin
                    conv_start_s = 1'b0;
                end
            end
            ST_CONVERT: begin
                if (conv_done_s && pend_full_r) begin
                    conv_start_s = 1'b1;
                    conv_val_s   = pend_val_r;
                end else if (conv_done_s && value_valid_i) begin
                    conv_start_s = 1'b1;
                end else begin
                    conv_start_s = 1'b0;
                end
            end
            default: begin
                conv_start_s = 1'b0;
            end
        endcase
    end

    // Encode the finished BCD, blanking zeros above the most significant nonzero digit
    always_comb begin
        seg_next_s = '0;
        lead_s     = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if ((LZ_BLANK != 0) && (k != 0) && lead_s && (conv_bcd_s[4*k +: 4] == 4'd0)) begin
                seg_next_s[7*k +: 7] = SEG_BLANK;
            end else begin
                seg_next_s[7*k +: 7] = seg7_enc(conv_bcd_s[4*k +: 4]);
                lead_s               = 1'b0;
            end
        end
    end

    // Control FSM, pending slot, hold timer and registered display outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            pend_full_r <= 1'b0;
            pend_val_r  <= '0;
            hold_r      <= '0;
            seg_r       <= {DIGITS{SEG_BLANK}};
            done_r      <= 1'b0;
            active_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (value_valid_i) begin
                        state_r <= ST_CONVERT;
                    end
                end
                ST_SHOW: begin
                    // A strobe on the timeout cycle wins over blanking
                    if (value_valid_i) begin
                        state_r <= ST_CONVERT;
                    end else if (hold_r == HOLD_W'(1)) begin
                        state_r  <= ST_IDLE;
                        seg_r    <= {DIGITS{SEG_BLANK}};
                        active_r <= 1'b0;
                        hold_r   <= '0;
                    end else if (hold_r != '0) begin
                        hold_r <= hold_r - 1'b1;
                    end
                end
                ST_CONVERT: begin
                    if (conv_done_s) begin
                        seg_r    <= seg_next_s;
                        done_r   <= 1'b1;
                        active_r <= 1'b1;
                        hold_r   <= HOLD_LOAD;
                        if (pend_full_r) begin
                            // Pending value restarts the converter; a same-cycle strobe refills the slot
                            pend_full_r <= value_valid_i;
                            pend_val_r  <= value_i;
                        end else if (!value_valid_i) begin
                            state_r <= ST_SHOW;
                        end
                    end else if (value_valid_i) begin
                        pend_full_r <= 1'b1;
                        pend_val_r  <= value_i;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign seg_o    = seg_r;
    assign busy_o   = conv_busy_s;
    assign active_o = active_r;
    assign done_o   = done_r;

endmodule

// File: tb/tb_seg_value_display.sv
// Bench for seg_value_display: a value-level model checked every cycle plus
// directed scenarios with hand-computed segment patterns.
module tb_seg_value_display;
    import seg_disp_pkg::*;

    typedef struct packed {
        int phase;   // 0 idle, 1 converting, 2 showing
        int left;    // conversion cycles still to run
        int cur;     // value being converted
        bit pf;      // pending slot full
        int pv;      // pending value
        int shown;   // value on the display, -1 when blank
        bit done;
        int hold;
    } mdl_t;

    localparam mdl_t MDL_RST = '{phase: 0, left: 0, cur: 0, pf: 1'b0, pv: 0,
                                 shown: -1, done: 1'b0, hold: 0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        va = 1'b0;
    logic [6:0]  vala = 7'd0;
    logic        vb = 1'b0;
    logic [9:0]  valb = 10'd0;
    logic [20:0] seg_a;
    logic [27:0] seg_b;
    logic        busy_a, active_a, done_a;
    logic        busy_b, active_b, done_b;
    int          checks = 0;
    int          failures = 0;
    mdl_t        ma, mb;
    logic [27:0] exp_seg_a, exp_seg_b;

    seg_value_display #(.VAL_W(7), .DIGITS(3), .LZ_BLANK(1), .HOLD_CYCLES(20)) dut_a (
        .clk_i(clk), .rst_i(rst), .value_i(vala), .value_valid_i(va),
        .seg_o(seg_a), .busy_o(busy_a), .active_o(active_a), .done_o(done_a));

    seg_value_display #(.VAL_W(10), .DIGITS(4), .LZ_BLANK(0), .HOLD_CYCLES(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .value_i(valb), .value_valid_i(vb),
        .seg_o(seg_b), .busy_o(busy_b), .active_o(active_b), .done_o(done_b));

    always #5 clk = ~clk;

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    // Decimal rendering of a value straight from digit arithmetic
    function automatic logic [27:0] render(input int shown, input int digits, input bit lz);
        logic [27:0] r;
        int p;
        r = '1;
        p = 1;
        if (shown >= 0) begin
            for (int k = 0; k < digits; k++) begin
                if (!(lz && k > 0 && shown < p)) r[7*k +: 7] = enc((shown / p) % 10);
                p = p * 10;
            end
        end
        return r;
    endfunction

    function automatic int seg_to_int(input logic [27:0] s, input int digits);
        int val, p, d;
        val = 0;
        p = 1;
        for (int k = 0; k < digits; k++) begin
            d = -1;
            for (int j = 0; j < 10; j++) if (s[7*k +: 7] == enc(j)) d = j;
            if (d < 0) return -1;
            val = val + d * p;
            p = p * 10;
        end
        return val;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input bit v, input int val,
                                      input int vw, input int hold_cyc);
        mdl_t n;
        n = m;
        n.done = 1'b0;
        if (m.phase != 1) begin
            if (v) begin
                n.phase = 1; n.left = vw; n.cur = val;
            end else if (m.phase == 2 && hold_cyc > 0) begin
                if (m.hold <= 1) begin n.phase = 0; n.shown = -1; end
                else n.hold = m.hold - 1;
            end
        end else begin
            n.left = m.left - 1;
            if (n.left == 0) begin
                n.shown = m.cur; n.done = 1'b1; n.hold = hold_cyc;
                if (m.pf) begin
                    n.cur = m.pv; n.left = vw; n.pf = v; n.pv = val;
                end else if (v) begin
                    n.cur = val; n.left = vw;
                end else begin
                    n.phase = 2;
                end
            end else if (v) begin
                n.pf = 1'b1; n.pv = val;
            end
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model advances on the same edges as the DUTs
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= MDL_RST;
            mb <= MDL_RST;
        end else begin
            ma <= mdl_step(ma, va, int'(vala), 7, 20);
            mb <= mdl_step(mb, vb, int'(valb), 10, 0);
        end
    end

    assign exp_seg_a = render(ma.shown, 3, 1'b1) & 28'h01FFFFF;
    assign exp_seg_b = render(mb.shown, 4, 1'b0);

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            check("a_seg",    28'(seg_a),    exp_seg_a);
            check("a_busy",   28'(busy_a),   28'(ma.phase == 1));
            check("a_active", 28'(active_a), 28'(ma.shown >= 0));
            check("a_done",   28'(done_a),   28'(ma.done));
            check("b_seg",    seg_b,         exp_seg_b);
            check("b_busy",   28'(busy_b),   28'(mb.phase == 1));
            check("b_active", 28'(active_b), 28'(mb.shown >= 0));
            check("b_done",   28'(done_b),   28'(mb.done));
        end
    end

    task automatic pulse_a(input int v);
        va = 1'b1; vala = 7'(v);
        @(negedge clk);
        va = 1'b0;
    endtask

    task automatic pulse_b(input int v);
        vb = 1'b1; valb = 10'(v);
        @(negedge clk);
        vb = 1'b0;
    endtask

    // Wait (bounded) for done on the selected DUT, counting busy cycles seen
    task automatic wait_done(input bit sel, output int bcyc);
        bit got;
        got = 1'b0;
        bcyc = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (sel ? done_b : done_a) got = 1'b1;
            else begin
                if (sel ? busy_b : busy_a) bcyc++;
                @(negedge clk);
            end
        end
        check(sel ? "b_done_timeout" : "a_done_timeout", 28'(got), 28'd1);
    endtask

    initial begin
        int bc, dones, dec;
        bit seen42;
        logic [20:0] first_seg, last_seg;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state and model pinning
        check("rst_seg",    28'(seg_a), 28'h01FFFFF);
        check("rst_busy",   28'(busy_a), 28'd0);
        check("rst_active", 28'(active_a), 28'd0);
        check("rst_done",   28'(done_a), 28'd0);
        check("pkg_ok_10_3", 28'(digits_ok(10, 3)), 28'd0);
        check("pkg_ok_10_4", 28'(digits_ok(10, 4)), 28'd1);
        check("model_305", render(305, 3, 1'b1) & 28'h01FFFFF,
              28'({7'b0110000, 7'b1000000, 7'b0010010}));

        // Value 100: seven busy cycles, then digits 1 0 0
        pulse_a(100);
        wait_done(1'b0, bc);
        check("t1_busy_cycles", 28'(bc), 28'd7);
        check("t1_seg", 28'(seg_a), 28'({7'b1111001, 7'b1000000, 7'b1000000}));

        // Leading-zero blanking on and off, and value 0
        pulse_a(7);
        wait_done(1'b0, bc);
        check("t2_seg7_lz", 28'(seg_a), 28'({7'h7F, 7'h7F, 7'b1111000}));
        pulse_b(7);
        wait_done(1'b1, bc);
        check("t2_seg7_nolz", seg_b, 28'({7'b1000000, 7'b1000000, 7'b1000000, 7'b1111000}));
        pulse_a(0);
        wait_done(1'b0, bc);
        check("t2_seg0", 28'(seg_a), 28'({7'h7F, 7'h7F, 7'b1000000}));

        // 127, then 5 followed by 42 and 99 during the conversion
        pulse_a(127);
        wait_done(1'b0, bc);
        check("t3_seg127", 28'(seg_a), 28'({7'b1111001, 7'b0100100, 7'b1111000}));
        va = 1'b1; vala = 7'd5;
        @(negedge clk);
        vala = 7'd42;
        @(negedge clk);
        vala = 7'd99;
        @(negedge clk);
        va = 1'b0;
        dones = 0; seen42 = 1'b0; first_seg = '0; last_seg = '0;
        for (int i = 0; i < 25; i++) begin
            if (done_a) begin
                dones++;
                if (dones == 1) first_seg = seg_a;
                last_seg = seg_a;
            end
            if (seg_a == {7'h7F, 7'b0011001, 7'b0100100}) seen42 = 1'b1;
            @(negedge clk);
        end
        check("t3_done_pulses", 28'(dones), 28'd2);
        check("t3_first_seg5", 28'(first_seg), 28'({7'h7F, 7'h7F, 7'b0010010}));
        check("t3_last_seg99", 28'(last_seg), 28'({7'h7F, 7'b0010000, 7'b0010000}));
        check("t3_never42", 28'(seen42), 28'd0);

        // Hold timer expiry after 20 cycles
        pulse_a(55);
        wait_done(1'b0, bc);
        check("t4_seg55", 28'(seg_a), 28'({7'h7F, 7'b0010010, 7'b0010010}));
        repeat (19) @(negedge clk);
        check("t4_active_last", 28'(active_a), 28'd1);
        @(negedge clk);
        check("t4_active_off", 28'(active_a), 28'd0);
        check("t4_seg_blank", 28'(seg_a), 28'h01FFFFF);

        // Strobe on the timeout cycle wins over blanking
        pulse_a(55);
        wait_done(1'b0, bc);
        repeat (19) @(negedge clk);
        va = 1'b1; vala = 7'd33;
        @(negedge clk);
        va = 1'b0;
        check("t4b_active", 28'(active_a), 28'd1);
        check("t4b_busy", 28'(busy_a), 28'd1);
        check("t4b_seg_kept", 28'(seg_a), 28'({7'h7F, 7'b0010010, 7'b0010010}));
        wait_done(1'b0, bc);
        check("t4b_seg33", 28'(seg_a), 28'({7'h7F, 7'b0110000, 7'b0110000}));

        // Asynchronous reset mid-conversion with a pending value
        pulse_a(88);
        va = 1'b1; vala = 7'd11;
        @(negedge clk);
        va = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_seg_blank", 28'(seg_a), 28'h01FFFFF);
        check("t5_busy", 28'(busy_a), 28'd0);
        check("t5_active", 28'(active_a), 28'd0);
        check("t5_done", 28'(done_a), 28'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_a) dones++;
        end
        check("t5_no_done", 28'(dones), 28'd0);

        // Exhaustive sweep on the 10-bit, 4-digit instance
        for (int v = 0; v < 1024; v++) begin
            pulse_b(v);
            wait_done(1'b1, bc);
            dec = seg_to_int(seg_b, 4);
            check("t6_sweep", 28'(dec), 28'(v));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
